window_read_sequencer: RTL

- Consumer side of the RAM read-window interface. Takes the window lower limit (base address) and issues every read address of a KxK convolution window to the feature-map RAM, one per valid/ready handshake.
- After the last address it pulses a sum-enable so the upstream lower-limit register advances to the next window.
- Sits between the lower-limit register and the feature-map RAM read port in the convolution datapath.

---
 rtl/window_reader_pkg.sv | 14 +
 rtl/window_pos_counter.sv | 60 ++++++
 rtl/window_read_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/window_reader_pkg.sv
// Shared state encoding and default widths for the window read path; also used by the
// lower-limit register and the RAM wrapper.
package window_reader_pkg;

  localparam int unsigned DefAddrWidth  = 10;
  localparam int unsigned DefKsizeWidth = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/window_pos_counter.sv
// Nested row/col position counter for a KxK window, with row_base accumulator,
// look-ahead next address and last-position flag.
module window_pos_counter
  import window_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned KSIZE_WIDTH = DefKsizeWidth
) (
  input  logic                   POS_COUNTER_clk,
  input  logic                   POS_COUNTER_Reset,
  input  logic                   POS_COUNTER_Load,
  input  logic                   POS_COUNTER_Step,
  input  logic [ADDR_WIDTH-1:0]  POS_COUNTER_Base,
  input  logic [ADDR_WIDTH-1:0]  POS_COUNTER_Row_Stride,
  input  logic [KSIZE_WIDTH-1:0] POS_COUNTER_Ksize,
  output logic [ADDR_WIDTH-1:0]  POS_COUNTER_Next_Addr,
  output logic                   POS_COUNTER_Last
);

  logic [KSIZE_WIDTH-1:0] row_q, col_q, k_q, k_max;
  logic [ADDR_WIDTH-1:0]  row_base_q, stride_q;
  logic                   col_last, row_last;

  assign k_max    = k_q - KSIZE_WIDTH'(1);
  assign col_last = (col_q == k_max);
  assign row_last = (row_q == k_max);

  assign POS_COUNTER_Last = col_last && row_last;

  // Address presented after the next handshake; sums truncate to ADDR_WIDTH.
  assign POS_COUNTER_Next_Addr = col_last ? (row_base_q + stride_q)
                                          : (row_base_q + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1));

  always_ff @(posedge POS_COUNTER_clk or posedge POS_COUNTER_Reset) begin
    if (POS_COUNTER_Reset) begin
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
    end else if (POS_COUNTER_Load) begin
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= POS_COUNTER_Ksize;
      row_base_q <= POS_COUNTER_Base;
      stride_q   <= POS_COUNTER_Row_Stride;
    end else if (POS_COUNTER_Step) begin
      if (col_last) begin
        col_q <= '0;
        if (!row_last) begin
          row_q      <= row_q + KSIZE_WIDTH'(1);
          row_base_q <= row_base_q + stride_q;
        end
      end else begin
        col_q <= col_q + KSIZE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/window_read_sequencer.sv
// Issues the K*K read addresses of one convolution window, row-major, over a valid/ready
// port, then pulses Done/Sum_En so the lower-limit register advances.
module window_read_sequencer
  import window_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned KSIZE_WIDTH = DefKsizeWidth
) (
  input  logic                   WINDOW_READER_clk,
  input  logic                   WINDOW_READER_Reset,
  input  logic                   WINDOW_READER_Start,
  input  logic [ADDR_WIDTH-1:0]  WINDOW_READER_Base,
  input  logic [ADDR_WIDTH-1:0]  WINDOW_READER_Row_Stride,
  input  logic [KSIZE_WIDTH-1:0] WINDOW_READER_Ksize,
  output logic [ADDR_WIDTH-1:0]  WINDOW_READER_Addr,
  output logic                   WINDOW_READER_Addr_Valid,
  input  logic                   WINDOW_READER_Addr_Ready,
  output logic                   WINDOW_READER_Busy,
  output logic                   WINDOW_READER_Done,
  output logic                   WINDOW_READER_Sum_En
);

  wr_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  logic                  valid_q, busy_q, done_q, sum_en_q;
  logic                  load, step, last;

  assign load = (state_q == StIdle) && WINDOW_READER_Start;
  assign step = (state_q == StIssue) && valid_q && WINDOW_READER_Addr_Ready;

  window_pos_counter #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .KSIZE_WIDTH (KSIZE_WIDTH)
  ) u_pos (
    .POS_COUNTER_clk        (WINDOW_READER_clk),
    .POS_COUNTER_Reset      (WINDOW_READER_Reset),
    .POS_COUNTER_Load       (load),
    .POS_COUNTER_Step       (step),
    .POS_COUNTER_Base       (WINDOW_READER_Base),
    .POS_COUNTER_Row_Stride (WINDOW_READER_Row_Stride),
    .POS_COUNTER_Ksize      (WINDOW_READER_Ksize),
    .POS_COUNTER_Next_Addr  (next_addr),
    .POS_COUNTER_Last       (last)
  );

  always_ff @(posedge WINDOW_READER_clk or posedge WINDOW_READER_Reset) begin
    if (WINDOW_READER_Reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_en_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      sum_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            addr_q <= WINDOW_READER_Base;
            busy_q <= 1'b1;
            if (WINDOW_READER_Ksize != '0) begin
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StIssue: begin
          if (step) begin
            if (last) begin
              state_q  <= StDone;
              valid_q  <= 1'b0;
              done_q   <= 1'b1;
              sum_en_q <= 1'b1;
            end else begin
              addr_q <= next_addr;
            end
          end
        end
        StDone: begin
          // A K=0 sweep arrives here without the pulse armed; it spends one extra
          // DONE cycle raising it so Done always coincides with a DONE-state cycle.
          if (done_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            done_q   <= 1'b1;
            sum_en_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign WINDOW_READER_Addr       = addr_q;
  assign WINDOW_READER_Addr_Valid = valid_q;
  assign WINDOW_READER_Busy       = busy_q;
  assign WINDOW_READER_Done       = done_q;
  assign WINDOW_READER_Sum_En     = sum_en_q;

endmodule
